// File: rtl/m_wb_initiator.sv
// m_wb_initiator: single-outstanding Wishbone classic initiator with timeout and latency report
//   CLK_I, RST_I (async, active-low)
//   req_valid/req_ready/req_we/req_adr/req_dat/req_sel : host request handshake
//   timeout_limit : max unacknowledged STB cycles, 0 = no timeout
//   rsp_valid/rsp_dat/rsp_err/rsp_lat : one-cycle completion strobe with held result
//   CYC_O/STB_O/WE_O/ADR_O/DAT_O/SEL_O, ACK_I/DAT_I : Wishbone bus
//   busy : not idle
module m_wb_initiator #(
  parameter int TIMEOUT_W = 8
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_adr,
  input  logic [31:0]          req_dat,
  input  logic [3:0]           req_sel,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  output logic [TIMEOUT_W-1:0] rsp_lat,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic                 WE_O,
  output logic [31:0]          ADR_O,
  output logic [31:0]          DAT_O,
  output logic [3:0]           SEL_O,
  input  logic                 ACK_I,
  input  logic [31:0]          DAT_I,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [TIMEOUT_W-1:0] cnt, cnt_sat;
  logic [TIMEOUT_W:0] cnt_inc;
  logic accept, ack, tmo;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) state <= IDLE;
    else state <= state_nxt;
  // cnt_inc is one bit wider so the timeout compare cannot alias on wrap
  always_comb begin
    cnt_inc = {1'b0, cnt} + (TIMEOUT_W+1)'(1);
    cnt_sat = &cnt ? cnt : cnt_inc[TIMEOUT_W-1:0];
    accept = state == IDLE && req_valid;
    ack = state == WAIT && ACK_I;
    tmo = state == WAIT && !ACK_I && timeout_limit != '0 && cnt_inc == {1'b0, timeout_limit};
    state_nxt = accept ? WAIT : (ack || tmo) ? RESP : state == RESP ? IDLE : state;
  end
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      CYC_O <= 1'b0;
      WE_O <= 1'b0;
      ADR_O <= '0;
      DAT_O <= '0;
      SEL_O <= '0;
      rsp_dat <= '0;
      rsp_err <= 1'b0;
      rsp_lat <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        CYC_O <= 1'b1;
        WE_O <= req_we;
        ADR_O <= req_adr;
        DAT_O <= req_dat;
        SEL_O <= req_sel;
        cnt <= '0;
      end
      if (ack) begin
        CYC_O <= 1'b0;
        rsp_dat <= WE_O ? '0 : DAT_I;
        rsp_err <= 1'b0;
        rsp_lat <= cnt;
      end
      if (state == WAIT && !ACK_I) cnt <= cnt_sat;
      // the cycle that times out is itself an unacknowledged STB cycle
      if (tmo) begin
        CYC_O <= 1'b0;
        rsp_dat <= '0;
        rsp_err <= 1'b1;
        rsp_lat <= cnt_sat;
      end
    end
  assign STB_O = CYC_O;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
endmodule

// File: tb/tb_m_wb_initiator.sv
// tb_m_wb_initiator: directed self-checking bench with a schedule-based expectation model
module tb_m_wb_initiator;
  localparam int W = 8;
  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_adr = '0, req_dat = '0;
  logic [3:0] req_sel = '0;
  logic [W-1:0] timeout_limit = '0;
  logic ACK_I = 1'b0;
  logic [31:0] DAT_I = '0;
  logic req_ready, rsp_valid, rsp_err, CYC_O, STB_O, WE_O, busy;
  logic [31:0] rsp_dat, ADR_O, DAT_O;
  logic [W-1:0] rsp_lat;
  logic [3:0] SEL_O;
  m_wb_initiator #(.TIMEOUT_W(W)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .timeout_limit(timeout_limit), .rsp_valid(rsp_valid), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_lat(rsp_lat), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .ACK_I(ACK_I), .DAT_I(DAT_I), .busy(busy)
  );
  always #5 CLK_I = ~CLK_I;
  int checks = 0, fails = 0;
  logic e_ready = 1'b1, e_busy = 1'b0, e_cyc = 1'b0, e_rv = 1'b0, e_we = 1'b0, e_err = 1'b0;
  logic [31:0] e_adr = '0, e_dat = '0, e_rdat = '0;
  logic [3:0] e_sel = '0;
  logic [W-1:0] e_lat = '0;
  int run = 0, last_run = 0, cyc_n = 0, rv_cnt = 0, last_rv = 0, prev_rv = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge CLK_I) begin
    cyc_n++;
    chk("req_ready", req_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("CYC_O", CYC_O, e_cyc);
    chk("STB_O", STB_O, e_cyc);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("WE_O", WE_O, e_we);
    chk("ADR_O", ADR_O, e_adr);
    chk("DAT_O", DAT_O, e_dat);
    chk("SEL_O", SEL_O, e_sel);
    chk("rsp_dat", rsp_dat, e_rdat);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_lat", rsp_lat, e_lat);
    if (CYC_O === 1'b1) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (rsp_valid === 1'b1) begin
      rv_cnt++;
      prev_rv = last_rv;
      last_rv = cyc_n;
    end
  end
  // Called at #1 after a posedge in an idle cycle. n = unacked STB cycles before ACK, -1 = never.
  task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic [W-1:0] lim, input int n, input logic [31:0] din, input bit hold, input bit stray);
    int k, lat;
    bit tmo;
    tmo = lim != 0 && (n < 0 || n >= int'(lim));
    k = tmo ? int'(lim) : n + 1;
    lat = tmo ? int'(lim) : n;
    if (lat > 2**W - 1) lat = 2**W - 1;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    timeout_limit = lim; ACK_I = stray; DAT_I = 32'h0BAD0BAD;
    for (int i = 1; i <= k; i++) begin
      @(posedge CLK_I); #1;
      if (i == 1) begin e_we = we; e_adr = adr; e_dat = dat; e_sel = sel; end
      e_ready = 1'b0; e_busy = 1'b1; e_cyc = 1'b1; e_rv = 1'b0;
      req_valid = hold; req_we = ~we; req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom);
      ACK_I = n >= 0 && i == n + 1;
      DAT_I = ACK_I ? din : $urandom;
    end
    @(posedge CLK_I); #1;
    e_cyc = 1'b0; e_rv = 1'b1;
    e_rdat = (tmo || we) ? 32'h0 : din; e_err = tmo; e_lat = W'(lat);
    ACK_I = stray; DAT_I = $urandom;
    @(posedge CLK_I); #1;
    e_rv = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int rv0;
    #2 RST_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1 RST_I = 1'b1;
    txn(1'b1, 32'h60000004, 32'hA5A51234, 4'hF, 8'd0, 0, 32'h0, 1'b0, 1'b0);
    chk("w0 run", last_run, 1); chk("w0 err", rsp_err, 0); chk("w0 dat", rsp_dat, 0); chk("w0 lat", rsp_lat, 0);
    txn(1'b0, 32'h10000040, 32'h0, 4'h3, 8'd0, 5, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("r5 run", last_run, 6); chk("r5 dat", rsp_dat, 32'hDEADBEEF); chk("r5 lat", rsp_lat, 5); chk("r5 err", rsp_err, 0);
    txn(1'b0, 32'h20000000, 32'h0, 4'hF, 8'd4, -1, 32'h0, 1'b0, 1'b0);
    chk("to run", last_run, 4); chk("to err", rsp_err, 1); chk("to dat", rsp_dat, 0); chk("to lat", rsp_lat, 4);
    txn(1'b0, 32'h20000010, 32'h0, 4'h1, 8'd3, 2, 32'hCAFEF00D, 1'b0, 1'b0);
    chk("co run", last_run, 3); chk("co err", rsp_err, 0); chk("co dat", rsp_dat, 32'hCAFEF00D); chk("co lat", rsp_lat, 2);
    txn(1'b1, 32'h30000008, 32'h12345678, 4'h5, 8'd10, 3, 32'hFFFFFFFF, 1'b0, 1'b1);
    chk("w3 run", last_run, 4); chk("w3 dat", rsp_dat, 0); chk("w3 lat", rsp_lat, 3);
    txn(1'b0, 32'h30000000, 32'h0, 4'hF, 8'd1, -1, 32'h0, 1'b0, 1'b0);
    chk("to1 run", last_run, 1); chk("to1 err", rsp_err, 1); chk("to1 lat", rsp_lat, 1);
    txn(1'b0, 32'h40000000, 32'h0, 4'hF, 8'd0, 300, 32'h55AA55AA, 1'b0, 1'b0);
    chk("sat lat", rsp_lat, 255); chk("sat dat", rsp_dat, 32'h55AA55AA);
    rv0 = rv_cnt;
    txn(1'b1, 32'h50000000, 32'h00000001, 4'h1, 8'd0, 0, 32'h0, 1'b1, 1'b1);
    txn(1'b0, 32'h50000004, 32'h0, 4'h2, 8'd0, 0, 32'h11112222, 1'b1, 1'b1);
    txn(1'b1, 32'h50000008, 32'h00000003, 4'h4, 8'd0, 0, 32'h0, 1'b1, 1'b1);
    req_valid = 1'b0; ACK_I = 1'b0;
    @(negedge CLK_I);
    chk("b2b pulses", rv_cnt - rv0, 3); chk("b2b period", last_rv - prev_rv, 3);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h70000000; req_dat = 32'h0; req_sel = 4'hF;
    timeout_limit = 8'd0; ACK_I = 1'b0;
    @(posedge CLK_I); #1;
    e_we = 1'b0; e_adr = 32'h70000000; e_dat = 32'h0; e_sel = 4'hF;
    e_ready = 1'b0; e_busy = 1'b1; e_cyc = 1'b1;
    req_valid = 1'b0;
    @(posedge CLK_I); #1;
    chk("rst pre cyc", CYC_O, 1);
    RST_I = 1'b0;
    e_ready = 1'b1; e_busy = 1'b0; e_cyc = 1'b0; e_rv = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_rdat = '0; e_err = 1'b0; e_lat = '0;
    #1;
    chk("rst async cyc", CYC_O, 0); chk("rst async stb", STB_O, 0);
    rv0 = rv_cnt;
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b1;
    chk("rst ready", req_ready, 1);
    txn(1'b0, 32'h70000004, 32'h0, 4'hC, 8'd0, 1, 32'h87654321, 1'b0, 1'b0);
    chk("rst rv count", rv_cnt - rv0, 1); chk("post rst dat", rsp_dat, 32'h87654321); chk("post rst lat", rsp_lat, 1);
    @(negedge CLK_I);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
